// File: rtl/slice_gatherer.sv
// slice_gatherer: packs a stream of SLICE_W-bit slices into SLICES*SLICE_W-bit words.
// The input and the output each use a valid/ready handshake. When in_last ends a
// word early, the word is short and its unfilled slices are zero.
// Optional feature macro: SLICE_GATHERER_MSB_FIRST_EN. It places slice 0 in the
// most-significant slot, so a partial word is left-justified.
module slice_gatherer #(
    parameter int SLICE_W = 3,
    parameter int SLICES  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [SLICE_W-1:0]           in_data,
    input  logic                         in_valid,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic [SLICES*SLICE_W-1:0]    out_data,
    output logic [$clog2(SLICES+1)-1:0]  out_count,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int WORD_W = SLICES * SLICE_W;
    localparam int CNT_W  = $clog2(SLICES);
    localparam int OCNT_W = $clog2(SLICES + 1);

    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] acc;
    logic [WORD_W-1:0] slot;
    logic [WORD_W-1:0] merged;
    logic              accept;
    logic              done;

    // A slice can enter whenever the word register is empty or is being drained.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign done     = accept && (in_last || (cnt == CNT_W'(SLICES - 1)));

    // Place the incoming slice at the slot selected by the slice counter.
    always_comb begin
        slot = '0;
        for (int k = 0; k < SLICES; k++) begin
            if (int'(cnt) == k) begin
`ifdef SLICE_GATHERER_MSB_FIRST_EN
                slot[(SLICES-1-k)*SLICE_W +: SLICE_W] = in_data;
`else
                slot[k*SLICE_W +: SLICE_W] = in_data;
`endif
            end
        end
        merged = acc | slot;
    end

    // Accumulate slices and hand finished words to the output register.
    // A finishing word may load on the same edge that the consumer takes the
    // previous one, which keeps the rate at one slice per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (done) begin
                out_data  <= merged;
                out_count <= OCNT_W'(cnt) + OCNT_W'(1);
                out_valid <= 1'b1;
                cnt       <= '0;
                acc       <= '0;
            end else if (accept) begin
                acc <= merged;
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_slice_gatherer.sv
// Bench for slice_gatherer (SLICE_W=3, SLICES=4). The reference model is a
// queue of accepted slices plus a one-deep word register. Words are built
// arithmetically as the sum of slice * 2^(slot*SLICE_W).
module tb_slice_gatherer;

    localparam int SLICE_W = 3;
    localparam int SLICES  = 4;
    localparam int W       = SLICE_W * SLICES;

    logic                         clk = 1'b0;
    logic                         rst;
    logic [SLICE_W-1:0]           in_data;
    logic                         in_valid;
    logic                         in_last;
    logic                         in_ready;
    logic [W-1:0]                 out_data;
    logic [$clog2(SLICES+1)-1:0]  out_count;
    logic                         out_valid;
    logic                         out_ready;

    slice_gatherer #(.SLICE_W(SLICE_W), .SLICES(SLICES)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
        .out_count(out_count), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // model state
    int     q[$];
    bit     m_full  = 1'b0;
    longint m_data  = 0;
    int     m_count = 0;
    int     n_acc   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint build_word();
        longint w = 0;
        for (int k = 0; k < q.size(); k++) begin
`ifdef SLICE_GATHERER_MSB_FIRST_EN
            w = w + longint'(q[k]) * (longint'(1) << ((SLICES - 1 - k) * SLICE_W));
`else
            w = w + longint'(q[k]) * (longint'(1) << (k * SLICE_W));
`endif
        end
        return w;
    endfunction

    // One clock cycle: drive, check against the model, advance the model.
    task automatic step(input bit v, input int d, input bit l, input bit ordy, input bit r);
        bit acc_now;
        rst       = r;
        in_valid  = v;
        in_data   = SLICE_W'(d);
        in_last   = l;
        out_ready = ordy;
        #1;
        check("out_valid", 32'(out_valid), 32'(m_full));
        if (m_full) begin
            check("out_data", 32'(out_data), 32'(m_data));
            check("out_count", 32'(out_count), 32'(m_count));
        end
        if (!r) check("in_ready", 32'(in_ready), 32'(!m_full || ordy));
        if (r) begin
            q.delete();
            m_full = 1'b0;
        end else begin
            acc_now = v && (!m_full || ordy);
            if (m_full && ordy) m_full = 1'b0;
            if (acc_now) begin
                n_acc++;
                q.push_back(d);
                if (l || q.size() == SLICES) begin
                    m_data  = build_word();
                    m_count = q.size();
                    m_full  = 1'b1;
                    q.delete();
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    int start_acc;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        step(0, 0, 0, 0, 1);
        // reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);

        // 1: full word 1,2,3,4
        for (int i = 1; i <= 4; i++) step(1, i, 0, 1, 0);
`ifdef SLICE_GATHERER_MSB_FIRST_EN
        check("t1_data", 32'(out_data), 32'h29C);
`else
        check("t1_data", 32'(out_data), 32'h8D1);
`endif
        check("t1_count", 32'(out_count), 32'd4);
        check("t1_valid", 32'(out_valid), 32'd1);

        // 2: short word 5,6 with last
        step(1, 5, 0, 1, 0);
        step(1, 6, 1, 1, 0);
`ifdef SLICE_GATHERER_MSB_FIRST_EN
        check("t2_data", 32'(out_data), 32'hB80);
`else
        check("t2_data", 32'(out_data), 32'h035);
`endif
        check("t2_count", 32'(out_count), 32'd2);

        // 3: backpressure with a pending word and a waiting slice
        step(1, 1, 1, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 2, 0, 0, 0);
        check("t3_hold_ready", 32'(in_ready), 32'd0);
        step(1, 2, 0, 1, 0);
        for (int i = 3; i <= 5; i++) step(1, i, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        // 4: two words streamed, 8 slices in 8 cycles
        start_acc = n_acc;
        for (int i = 0; i < 8; i++) step(1, (i * 3 + 1) % 8, 0, 1, 0);
        check("t4_accepts", 32'(n_acc - start_acc), 32'd8);
        step(0, 0, 0, 1, 0);

        // 5: reset mid-word
        step(1, 7, 0, 1, 0);
        step(1, 7, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_data", 32'(out_data), 32'd0);
        check("t5_rst_count", 32'(out_count), 32'd0);
        for (int i = 1; i <= 4; i++) step(1, i, 0, 0, 0);
`ifdef SLICE_GATHERER_MSB_FIRST_EN
        check("t5_data", 32'(out_data), 32'h29C);
`else
        check("t5_data", 32'(out_data), 32'h8D1);
`endif
        check("t5_count", 32'(out_count), 32'd4);
        step(0, 0, 0, 1, 0);

        // 6: idle input with in_last toggling
        for (int i = 0; i < 10; i++) step(0, int'($urandom_range(7)), i[0], 1, 0);
        check("t6_valid", 32'(out_valid), 32'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(3) != 0, int'($urandom_range(7)),
                 $urandom_range(5) == 0, $urandom_range(9) < 7,
                 $urandom_range(299) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
